// File: rtl/vga_timing.sv
`timescale 1ns/1ps
// vga_timing: raster counters, sync/DE generation and pin-registered VGA output.
// Sync/DE travel through a PIPE_DELAY-deep shift so they meet frame_buffer pixels.
module vga_timing #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 88,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 13,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 29,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int PIPE_DELAY = 2,
    parameter int COLOR_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            pixel_in,
    output logic [10:0]           vga_h,
    output logic [10:0]           vga_v,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic                  vga_de,
    output logic [COLOR_BITS-1:0] vga_r,
    output logic [COLOR_BITS-1:0] vga_g,
    output logic [COLOR_BITS-1:0] vga_b,
    output logic                  frame_start,
    output logic                  vblank
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_MAX    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_MAX    = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    // run_q is the release stage: the first clock after reset presents (0,0)
    // and raises frame_start before the raster starts counting.
    logic                  run_q,  run_d;
    logic [10:0]           h_q,    h_d;
    logic [10:0]           v_q,    v_d;
    logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_DELAY-1:0] de_pipe_q, de_pipe_d;
    logic                  hs_pin_q, hs_pin_d;
    logic                  vs_pin_q, vs_pin_d;
    logic                  de_pin_q, de_pin_d;
    logic [COLOR_BITS-1:0] r_pin_q,  r_pin_d;
    logic [COLOR_BITS-1:0] g_pin_q,  g_pin_d;
    logic [COLOR_BITS-1:0] b_pin_q,  b_pin_d;
    logic                  fs_q,     fs_d;

    logic hs_raw, vs_raw, de_raw, de_dly;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        run_d = 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (run_q) begin
            if (h_q == H_MAX) begin
                h_d = 11'd0;
                v_d = (v_q == V_MAX) ? 11'd0 : v_q + 11'd1;
            end else begin
                h_d = h_q + 11'd1;
            end
        end
        fs_d = (h_d == 11'd0) && (v_d == 11'd0);
    end

    always_comb begin
        de_raw = (h_q < H_ACT) && (v_q < V_ACT);
        hs_raw = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
        vs_raw = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_POL : ~VS_POL;

        hs_pipe_d = hs_pipe_q;
        vs_pipe_d = vs_pipe_q;
        de_pipe_d = de_pipe_q;
        if (run_q) begin
            hs_pipe_d[0] = hs_raw;
            vs_pipe_d[0] = vs_raw;
            de_pipe_d[0] = de_raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                hs_pipe_d[i] = hs_pipe_q[i-1];
                vs_pipe_d[i] = vs_pipe_q[i-1];
                de_pipe_d[i] = de_pipe_q[i-1];
            end
        end
    end

    // Colour is blanked by the delayed DE, which lines up with pixel_in.
    always_comb begin
        de_dly   = de_pipe_q[PIPE_DELAY-1];
        hs_pin_d = hs_pipe_q[PIPE_DELAY-1];
        vs_pin_d = vs_pipe_q[PIPE_DELAY-1];
        de_pin_d = de_dly;
        r_pin_d  = {COLOR_BITS{pixel_in[2] & de_dly}};
        g_pin_d  = {COLOR_BITS{pixel_in[1] & de_dly}};
        b_pin_d  = {COLOR_BITS{pixel_in[0] & de_dly}};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            h_q       <= 11'd0;
            v_q       <= 11'd0;
            hs_pipe_q <= {PIPE_DELAY{~HS_POL}};
            vs_pipe_q <= {PIPE_DELAY{~VS_POL}};
            de_pipe_q <= '0;
            hs_pin_q  <= ~HS_POL;
            vs_pin_q  <= ~VS_POL;
            de_pin_q  <= 1'b0;
            r_pin_q   <= '0;
            g_pin_q   <= '0;
            b_pin_q   <= '0;
            fs_q      <= 1'b0;
        end else begin
            run_q     <= run_d;
            h_q       <= h_d;
            v_q       <= v_d;
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
            de_pipe_q <= de_pipe_d;
            hs_pin_q  <= hs_pin_d;
            vs_pin_q  <= vs_pin_d;
            de_pin_q  <= de_pin_d;
            r_pin_q   <= r_pin_d;
            g_pin_q   <= g_pin_d;
            b_pin_q   <= b_pin_d;
            fs_q      <= fs_d;
        end
    end

    assign vga_h       = h_q;
    assign vga_v       = v_q;
    assign vga_hs      = hs_pin_q;
    assign vga_vs      = vs_pin_q;
    assign vga_de      = de_pin_q;
    assign vga_r       = r_pin_q;
    assign vga_g       = g_pin_q;
    assign vga_b       = b_pin_q;
    assign frame_start = fs_q;
    assign vblank      = (v_q >= V_ACT);

endmodule

// File: tb/tb_vga_timing.sv
`timescale 1ns/1ps
// Directed bench for vga_timing: a full-size instance for line behaviour and a
// short-frame instance (4 active + 7 blank lines) for frame-level timing.
module tb_vga_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst_s_n;
    logic        use_stub;
    logic [2:0]  pix_force, pix1, pix2, pixel_in, pixel_s;

    logic [10:0] h, v;
    logic        hs, vs, de, fs, vblank;
    logic [3:0]  r, g, b;

    logic [10:0] h_s, v_s;
    logic        hs_s, vs_s, de_s, fs_s, vblank_s;
    logic [3:0]  r_s, g_s, b_s;

    int checks   = 0;
    int failures = 0;

    wire [11:0] rgb   = {r, g, b};
    wire [11:0] rgb_s = {r_s, g_s, b_s};

    vga_timing dut (
        .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in),
        .vga_h(h), .vga_v(v), .vga_hs(hs), .vga_vs(vs), .vga_de(de),
        .vga_r(r), .vga_g(g), .vga_b(b), .frame_start(fs), .vblank(vblank)
    );

    vga_timing #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(3), .V_BP(2)) dut_s (
        .clk(clk), .rst_n(rst_s_n), .pixel_in(pixel_s),
        .vga_h(h_s), .vga_v(v_s), .vga_hs(hs_s), .vga_vs(vs_s), .vga_de(de_s),
        .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .frame_start(fs_s), .vblank(vblank_s)
    );

    function automatic logic [2:0] f_pix(input logic [10:0] hv);
        return hv[2:0] ^ 3'b101;
    endfunction

    function automatic logic [11:0] expand(input logic [2:0] p);
        return {{4{p[2]}}, {4{p[1]}}, {4{p[0]}}};
    endfunction

    // frame_buffer stand-in: pixel for counter value h appears two clocks later
    always @(posedge clk) begin
        pix1 <= f_pix(h);
        pix2 <= pix1;
    end
    assign pixel_in = use_stub ? pix2 : pix_force;

    task automatic test_reset;
        use_stub  = 1'b0;
        pix_force = 3'b111;
        pixel_s   = 3'b010;
        rst_n     = 1'b0;
        rst_s_n   = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({h, v} !== 22'd0) begin failures++; $display("FAIL reset_hv actual=%0d,%0d required=0,0", h, v); end
        checks++; if ({hs, vs, de} !== 3'b110) begin failures++; $display("FAIL reset_sync actual=%b required=110", {hs, vs, de}); end
        checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL reset_rgb actual=%h required=000", rgb); end
        checks++; if ({fs, vblank} !== 2'b00) begin failures++; $display("FAIL reset_status actual=%b required=00", {fs, vblank}); end
        rst_n   = 1'b1;
        rst_s_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (h !== 11'(i) || v !== 11'd0) begin failures++; $display("FAIL release_count i=%0d actual=%0d,%0d required=%0d,0", i, h, v, i); end
            checks++;
            if (fs !== (i == 0)) begin failures++; $display("FAIL release_fs i=%0d actual=%b required=%b", i, fs, (i == 0)); end
            checks++;
            if (i < 3) begin
                if ({hs, vs, de, rgb} !== {3'b110, 12'h000}) begin failures++; $display("FAIL release_idle i=%0d actual=%b/%h required=110/000", i, {hs, vs, de}, rgb); end
            end else begin
                if ({hs, vs, de, rgb} !== {3'b111, 12'hFFF}) begin failures++; $display("FAIL release_active i=%0d actual=%b/%h required=111/fff", i, {hs, vs, de}, rgb); end
            end
        end
    endtask

    task automatic test_line_wrap;
        bit found = 1'b0;
        use_stub = 1'b1;
        for (int n = 0; n < 1100 && !found; n++) begin
            @(negedge clk);
            if (h == 11'd1055) found = 1'b1;
        end
        checks++;
        if (!found || v !== 11'd0) begin failures++; $display("FAIL wrap_reach found=%0d v=%0d required found=1 v=0", found, v); end
        @(negedge clk);
        checks++;
        if ({h, v} !== {11'd0, 11'd1}) begin failures++; $display("FAIL wrap_next actual=%0d,%0d required=0,1", h, v); end
        checks++;
        if (fs !== 1'b0) begin failures++; $display("FAIL wrap_fs actual=%b required=0", fs); end
    endtask

    // Waits for a pin-level DE rising edge; returns 0 on timeout.
    task automatic wait_de_rise(output bit ok);
        logic prev = de;
        ok = 1'b0;
        for (int n = 0; n < 2200 && !ok; n++) begin
            @(negedge clk);
            if (de && !prev) ok = 1'b1;
            prev = de;
        end
    endtask

    task automatic test_line_timing;
        bit ok;
        int de_len = -1, hs_fall = -1, hs_low = 0, pix_err = 0;
        bit vs_bad = 1'b0;
        logic prev_hs = 1'b1;
        wait_de_rise(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL line_de_rise timeout"); end
        checks++;
        if (rgb !== expand(f_pix(11'd0))) begin failures++; $display("FAIL line_first_pixel actual=%h required=%h", rgb, expand(f_pix(11'd0))); end
        for (int j = 0; j < 1056; j++) begin
            if (j > 0) @(negedge clk);
            if (!de && de_len < 0) de_len = j;
            if (j < 800 && rgb !== expand(f_pix(11'(j)))) pix_err++;
            if (j == 799) begin
                checks++;
                if (rgb !== expand(f_pix(11'd799))) begin failures++; $display("FAIL line_last_pixel actual=%h required=%h", rgb, expand(f_pix(11'd799))); end
            end
            if (j == 800) begin
                checks++;
                if (rgb !== 12'h000) begin failures++; $display("FAIL line_after_active actual=%h required=000", rgb); end
            end
            if (!hs) hs_low++;
            if (!hs && prev_hs && hs_fall < 0) hs_fall = j;
            prev_hs = hs;
            if (!vs) vs_bad = 1'b1;
        end
        checks++; if (de_len != 800) begin failures++; $display("FAIL line_de_width actual=%0d required=800", de_len); end
        checks++; if (pix_err != 0) begin failures++; $display("FAIL line_pixel_align errors=%0d required=0", pix_err); end
        // de rise carries h=0 and hsync starts at h=840
        checks++; if (hs_fall != 840) begin failures++; $display("FAIL line_hs_offset actual=%0d required=840", hs_fall); end
        checks++; if (hs_low != 128) begin failures++; $display("FAIL line_hs_width actual=%0d required=128", hs_low); end
        checks++; if (vs_bad) begin failures++; $display("FAIL line_vs_active actual=low required=high"); end
    endtask

    task automatic test_colour;
        bit ok;
        bit fell = 1'b0;
        use_stub  = 1'b0;
        pix_force = 3'b001;
        wait_de_rise(ok);
        repeat (5) @(negedge clk);
        checks++;
        if (!ok || rgb !== 12'h00F) begin failures++; $display("FAIL colour_blue ok=%0d actual=%h required=00f", ok, rgb); end
        pix_force = 3'b111;
        for (int n = 0; n < 900 && !fell; n++) begin
            @(negedge clk);
            if (!de) fell = 1'b1;
        end
        repeat (10) @(negedge clk);
        checks++;
        if (!fell || de !== 1'b0 || rgb !== 12'h000) begin failures++; $display("FAIL colour_blank_fp de=%b actual=%h required=000", de, rgb); end
        repeat (60) @(negedge clk);
        checks++;
        if (hs !== 1'b0 || rgb !== 12'h000) begin failures++; $display("FAIL colour_blank_sync hs=%b actual=%h required=0/000", hs, rgb); end
    endtask

    task automatic test_frame;
        bit ok = 1'b0;
        int period = -1, de_cnt = 0, vs_low = 0, vs_first = -1;
        int vb_cnt = 0, vb_first = -1, rgb_err = 0;
        for (int n = 0; n < 12000 && !ok; n++) begin
            @(negedge clk);
            if (fs_s) ok = 1'b1;
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL frame_fs_first timeout"); end
        checks++;
        if (vblank_s !== 1'b0 || {h_s, v_s} !== 22'd0) begin failures++; $display("FAIL frame_origin vblank=%b hv=%0d,%0d required=0 0,0", vblank_s, h_s, v_s); end
        for (int n = 1; n < 12000 && period < 0; n++) begin
            @(negedge clk);
            if (n == 11615) begin
                checks++;
                if ({h_s, v_s} !== {11'd1055, 11'd10}) begin failures++; $display("FAIL frame_last_count actual=%0d,%0d required=1055,10", h_s, v_s); end
            end
            if (fs_s) period = n;
            if (de_s) de_cnt++;
            if (rgb_s !== (de_s ? 12'h0F0 : 12'h000)) rgb_err++;
            if (!vs_s) begin
                vs_low++;
                if (vs_first < 0) vs_first = n;
            end
            if (vblank_s) begin
                vb_cnt++;
                if (vb_first < 0) vb_first = n;
            end
        end
        checks++; if (period != 11616) begin failures++; $display("FAIL frame_period actual=%0d required=11616", period); end
        checks++; if (de_cnt != 3200) begin failures++; $display("FAIL frame_de_count actual=%0d required=3200", de_cnt); end
        checks++; if (vs_first != 6339) begin failures++; $display("FAIL frame_vs_start actual=%0d required=6339", vs_first); end
        checks++; if (vs_low != 3168) begin failures++; $display("FAIL frame_vs_width actual=%0d required=3168", vs_low); end
        checks++; if (vb_first != 4224) begin failures++; $display("FAIL frame_vblank_start actual=%0d required=4224", vb_first); end
        checks++; if (vb_cnt != 7392) begin failures++; $display("FAIL frame_vblank_len actual=%0d required=7392", vb_cnt); end
        checks++; if (rgb_err != 0) begin failures++; $display("FAIL frame_rgb errors=%0d required=0", rgb_err); end
    endtask

    task automatic test_reset_mid;
        bit ok = 1'b0;
        for (int n = 0; n < 2200 && !ok; n++) begin
            @(negedge clk);
            if (h == 11'd500 && v != 11'd0) ok = 1'b1;
        end
        checks++;
        if (!ok || de !== 1'b1) begin failures++; $display("FAIL mid_reach ok=%0d de=%b required=1,1", ok, de); end
        rst_n = 1'b0;
        #1;
        checks++; if ({h, v} !== 22'd0) begin failures++; $display("FAIL mid_hv actual=%0d,%0d required=0,0", h, v); end
        checks++; if ({hs, vs, de, fs} !== 4'b1100) begin failures++; $display("FAIL mid_idle actual=%b required=1100", {hs, vs, de, fs}); end
        checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL mid_rgb actual=%h required=000", rgb); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({h, v, fs} !== {11'd0, 11'd0, 1'b1}) begin failures++; $display("FAIL mid_restart actual=%0d,%0d fs=%b required=0,0 fs=1", h, v, fs); end
        @(negedge clk);
        checks++;
        if ({h, v, fs} !== {11'd1, 11'd0, 1'b0}) begin failures++; $display("FAIL mid_step actual=%0d,%0d fs=%b required=1,0 fs=0", h, v, fs); end
    endtask

    initial begin
        test_reset();
        test_line_wrap();
        test_line_timing();
        test_colour();
        test_frame();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
